wavetable_port_arbiter: RTL and testbench
=========================================

// Module: wavetable_port_arbiter
// PURPOSE
//   Sole owner of the single-port wavetable RAM. Shares it between the oscillator read path and
//   the I2C register path (idx/data/ctrl regs 0x13-0x15). Buffers host writes and sequences RAM clear.
//   Reads have priority, bounded by a write-starvation guard.
// PARAMETERS
//   ADDR_W       5   RAM address width (2**ADDR_W entries)
//   DATA_W       8   RAM word width
//   FIFO_DEPTH   4   host-write buffer entries (power of 2)
//   MAX_WR_WAIT  15  consecutive lost arbitrations before a pending write is forced
// PORTS
//   clk          in   1       system clock
//   rst_n        in   1       asynchronous active-low reset
//   cfg_idx      in   ADDR_W  reg_wavetable_idx[ADDR_W-1:0]
//   idx_load_stb in   1       1-cycle pulse: idx register written
//   cfg_data     in   DATA_W  reg_wavetable_data
//   cfg_wr_stb   in   1       1-cycle pulse: data register written
//   cfg_ctrl     in   8       reg_wavetable_ctrl: [0] wr_en, [1] auto_inc, [2] clear_req
//   rd_req       in   1       oscillator read request (1-cycle pulse)
//   rd_addr      in   ADDR_W  read address, sampled with rd_req
//   rd_valid     out  1       1-cycle pulse: rd_data valid
//   rd_data      out  DATA_W  read result, held until next rd_valid
//   mem_en       out  1       RAM access enable
//   mem_we       out  1       RAM write enable
//   mem_addr     out  ADDR_W  RAM address
//   mem_wdata    out  DATA_W  RAM write data
//   mem_rdata    in   DATA_W  RAM read data, valid 1 cycle after mem_en&!mem_we
//   busy         out  1       clear in progress or FIFO non-empty
//   overflow     out  1       sticky: a host write was dropped
//   wr_ptr       out  ADDR_W  current host write pointer (status readback)
// BEHAVIOUR
//   Reset: all outputs 0; FIFO empty; wr_ptr=0; state IDLE; starve counter 0; pending read cleared.
//   Pointer: idx_load_stb -> wr_ptr<=cfg_idx.
//   Host write: cfg_wr_stb & wr_en -> push {addr,cfg_data}.
//     addr = cfg_idx if idx_load_stb is asserted in the same cycle, else wr_ptr.
//     If auto_inc, wr_ptr <= addr+1 (wraps mod 2**ADDR_W); otherwise wr_ptr <= addr.
//   cfg_wr_stb with wr_en=0: ignored, no side effects.
//   FIFO full on push: data dropped, wr_ptr unchanged, overflow<=1.
//   overflow clears only while wr_en=0 (or on reset).
//   Arbitration, evaluated every cycle:
//     read candidate  = rd_req or a pending read.
//     write candidate = FIFO head (IDLE) or clear word (CLEAR).
//     Read wins unless starve_cnt==MAX_WR_WAIT; then the write wins.
//     starve_cnt increments when a write candidate loses; it clears on any write grant.
//   Losing read is held as pending and granted next cycle. A new rd_req overwrites a pending read.
//   Read latency: grant at cycle N, rd_valid at N+1 with mem_rdata. Uncontended latency is 1 cycle.
//   mem_* outputs are registered-free combinational from the grant. mem_en=0 when there is no candidate.
//   FSM, 2 states:
//     IDLE: on clear_req rising edge, arm clear. Once the FIFO is empty, go to CLEAR with clr_addr=0.
//     CLEAR: writes 0 to clr_addr on each write grant and increments it.
//       After addr 2**ADDR_W-1 is written, return to IDLE.
//       FIFO pushes during CLEAR are accepted but not drained, so they land after the clear.
//       clear_req edges during CLEAR are ignored.
//   Writes to the same address commit in push order. Simultaneous read and write never both drive the RAM.
//   Reset mid-operation: the clear is aborted and buffered writes are lost. No further mem_en until new traffic.
// STRUCTURE
//   synth_pkg:
//     WT_CTRL_WR_EN/AUTO_INC/CLEAR bit indices.
//     wt_state_t {WT_IDLE, WT_CLEAR}.
//     Wavetable register addresses 0x13-0x15.
//   Sub-module wt_wr_fifo: sync FIFO, width ADDR_W+DATA_W, depth FIFO_DEPTH.
//     Ports: push/pop, full/empty, async rst_n.
// TESTING
//   1. idx=5, ctrl=0x03, write A1,A2,A3, no reads -> RAM writes (5,A1),(6,A2),(7,A3); wr_ptr=8.
//   2. idx=31, auto_inc, write 11,22 -> writes at addr 31 then 0; wr_ptr=1.
//   3. One write buffered, rd_req every cycle -> write forced on the 16th cycle.
//      That read's rd_valid arrives 1 cycle late with correct data.
//   4. rd_req held every cycle, 5 host writes -> 5th dropped, overflow=1, wr_ptr advanced by 4.
//      ctrl=0x00 -> overflow=0.
//   5. ctrl[2] 0->1 -> 32 zero writes to addr 0..31, busy=1 throughout.
//      A host write issued mid-clear lands after addr 31; then busy=0.
//   6. rst_n low mid-clear -> next cycle mem_en=0, busy=0, wr_ptr=0, overflow=0.
//      After release, a read of a written address returns its data, uncontended 1-cycle latency.

Source files
------------

// File: rtl/wavetable_port_arbiter_pkg.sv
// Shared constants for the wavetable RAM arbiter: ctrl register bit map,
// I2C register addresses and the clear-sequencer state encoding.
package wavetable_port_arbiter_pkg;

  localparam int WT_CTRL_WR_EN    = 0;
  localparam int WT_CTRL_AUTO_INC = 1;
  localparam int WT_CTRL_CLEAR    = 2;

  localparam logic [7:0] WT_REG_IDX  = 8'h13;
  localparam logic [7:0] WT_REG_DATA = 8'h14;
  localparam logic [7:0] WT_REG_CTRL = 8'h15;

  typedef enum logic [0:0] {
    WT_IDLE  = 1'b0,
    WT_CLEAR = 1'b1
  } wt_state_t;

endpackage

// File: rtl/wavetable_port_arbiter_wt_wr_fifo.sv
// Small synchronous FIFO that buffers {addr,data} host writes ahead of the RAM.
// Pushes while full and pops while empty are ignored.
module wt_wr_fifo
  import wavetable_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wp;
  logic [PW:0]      r_rp;
  logic             w_wr;
  logic             w_rd;

  // Extra MSB on the pointers distinguishes full from empty.
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign o_dout  = r_mem[r_rp[PW-1:0]];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + (PW+1)'(1);
      if (w_rd) r_rp <= r_rp + (PW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/wavetable_port_arbiter.sv
// Single-port wavetable RAM owner: oscillator reads win arbitration, buffered host
// writes and the clear sequencer get forced through after MAX_WR_WAIT lost rounds.
module wavetable_port_arbiter
  import wavetable_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_WR_WAIT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_cfg_idx,
  input  logic              i_idx_load_stb,
  input  logic [DATA_W-1:0] i_cfg_data,
  input  logic              i_cfg_wr_stb,
  input  logic [7:0]        i_cfg_ctrl,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [ADDR_W-1:0] o_wr_ptr
);

  localparam int FW = ADDR_W + DATA_W;
  localparam int SW = $clog2(MAX_WR_WAIT + 1);

  wt_state_t         r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_pend_vld;
  logic              r_clr_armed;
  logic              r_clr_d;
  logic              r_rd_vld;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rd_hold;
  logic [SW-1:0]     r_starve;

  logic              w_push_req, w_push, w_drop, w_pop;
  logic [ADDR_W-1:0] w_push_addr;
  logic [FW-1:0]     w_fifo_dout;
  logic              w_fifo_full, w_fifo_empty;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_rd_cand, w_wr_cand, w_force, w_rd_gnt, w_wr_gnt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_clr_edge;
  logic              w_unused;

  assign w_unused    = ^i_cfg_ctrl[7:3];

  assign w_push_req  = i_cfg_wr_stb & i_cfg_ctrl[WT_CTRL_WR_EN];
  assign w_push_addr = i_idx_load_stb ? i_cfg_idx : r_wr_ptr;
  assign w_push      = w_push_req & ~w_fifo_full;
  assign w_drop      = w_push_req & w_fifo_full;

  wt_wr_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   ({w_push_addr, i_cfg_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head_addr = w_fifo_dout[FW-1:DATA_W];
  assign w_head_data = w_fifo_dout[DATA_W-1:0];

  // A fresh request takes precedence over a parked one.
  assign w_rd_cand = i_rd_req | r_pend_vld;
  assign w_rd_addr = i_rd_req ? i_rd_addr : r_pend_addr;
  assign w_wr_cand = (r_state == WT_CLEAR) | ~w_fifo_empty;
  assign w_force   = (r_starve == SW'(MAX_WR_WAIT));
  assign w_rd_gnt  = w_rd_cand & ~(w_wr_cand & w_force);
  assign w_wr_gnt  = w_wr_cand & ~w_rd_gnt;
  assign w_pop     = w_wr_gnt & (r_state == WT_IDLE);
  assign w_clr_edge = i_cfg_ctrl[WT_CTRL_CLEAR] & ~r_clr_d;

  assign o_mem_en    = w_rd_gnt | w_wr_gnt;
  assign o_mem_we    = w_wr_gnt;
  assign o_mem_addr  = w_rd_gnt ? w_rd_addr :
                       !w_wr_gnt ? '0 :
                       (r_state == WT_CLEAR) ? r_clr_addr : w_head_addr;
  assign o_mem_wdata = (w_wr_gnt && r_state == WT_IDLE) ? w_head_data : '0;

  assign o_rd_valid = r_rd_vld;
  assign o_rd_data  = r_rd_vld ? i_mem_rdata : r_rd_hold;
  assign o_busy     = (r_state == WT_CLEAR) | r_clr_armed | ~w_fifo_empty;
  assign o_overflow = r_overflow;
  assign o_wr_ptr   = r_wr_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_idx_load_stb) r_wr_ptr <= i_cfg_idx;
      if (w_push)
        r_wr_ptr <= i_cfg_ctrl[WT_CTRL_AUTO_INC] ? w_push_addr + ADDR_W'(1) : w_push_addr;
      if (!i_cfg_ctrl[WT_CTRL_WR_EN]) r_overflow <= 1'b0;
      else if (w_drop)                r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld    <= 1'b0;
      r_rd_hold   <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_starve    <= '0;
    end else begin
      r_rd_vld <= w_rd_gnt;
      if (r_rd_vld) r_rd_hold <= i_mem_rdata;
      if (w_rd_gnt) begin
        r_pend_vld <= 1'b0;
      end else if (i_rd_req) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= i_rd_addr;
      end
      if (w_wr_gnt)       r_starve <= '0;
      else if (w_wr_cand) r_starve <= r_starve + SW'(1);
    end
  end

  // Clear waits for the FIFO to drain so earlier host writes are not wiped out of order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= WT_IDLE;
      r_clr_addr  <= '0;
      r_clr_armed <= 1'b0;
      r_clr_d     <= 1'b0;
    end else begin
      r_clr_d <= i_cfg_ctrl[WT_CTRL_CLEAR];
      case (r_state)
        WT_IDLE: begin
          if (w_clr_edge) r_clr_armed <= 1'b1;
          if (r_clr_armed && w_fifo_empty) begin
            r_state     <= WT_CLEAR;
            r_clr_addr  <= '0;
            r_clr_armed <= 1'b0;
          end
        end
        WT_CLEAR: begin
          if (w_wr_gnt) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (r_clr_addr == '1) r_state <= WT_IDLE;
          end
        end
        default: r_state <= WT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_port_arbiter.sv
// Scoreboard bench: stimulus queues expected RAM writes and read data; a negedge
// monitor pops and compares whenever the DUT writes RAM or pulses rd_valid.
module tb_wavetable_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cfg_idx = '0;
  logic          idx_load_stb = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_wr_stb = 1'b0;
  logic [7:0]    cfg_ctrl = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid, mem_en, mem_we, busy, overflow;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr, wr_ptr;

  logic [DW-1:0]    ram [1<<AW];
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    rq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wavetable_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_idx(cfg_idx), .i_idx_load_stb(idx_load_stb),
    .i_cfg_data(cfg_data), .i_cfg_wr_stb(cfg_wr_stb), .i_cfg_ctrl(cfg_ctrl),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_overflow(overflow), .o_wr_ptr(wr_ptr)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en && mem_we) begin
        if (wq.size() == 0) chk("unexpected_ram_write", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        else chk("ram_write", {mem_addr, mem_wdata}, wq.pop_front());
      end
      if (rd_valid) begin
        if (rq.size() == 0) chk("unexpected_rd_valid", rd_data, 32'hFFFF_FFFF);
        else chk("rd_data", rd_data, rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hostwr(input logic ld, input logic [AW-1:0] idx, input logic [DW-1:0] d);
    cfg_idx = idx; idx_load_stb = ld; cfg_data = d; cfg_wr_stb = 1'b1;
    tick();
    idx_load_stb = 1'b0; cfg_wr_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int first_we;
    logic [DW-1:0] tbl [3];
    tbl[0] = 8'hA1; tbl[1] = 8'hA2; tbl[2] = 8'hA3;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_rd", {rd_valid, rd_data}, 0);
    chk("rst_status", {busy, overflow, wr_ptr}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: idx=5, auto-inc, three writes
    cfg_ctrl = 8'h03; cfg_idx = 5; idx_load_stb = 1'b1;
    tick();
    idx_load_stb = 1'b0;
    wq.push_back({5'd5, 8'hA1}); hostwr(1'b0, 0, 8'hA1);
    wq.push_back({5'd6, 8'hA2}); hostwr(1'b0, 0, 8'hA2);
    wq.push_back({5'd7, 8'hA3}); hostwr(1'b0, 0, 8'hA3);
    repeat (4) tick();
    @(negedge clk);
    chk("t1_wr_ptr", wr_ptr, 8);
    chk("t1_busy", busy, 0);

    // 2: idx load with write, wrap at 31
    tick();
    wq.push_back({5'd31, 8'h11}); hostwr(1'b1, 31, 8'h11);
    wq.push_back({5'd0,  8'h22}); hostwr(1'b0, 0, 8'h22);
    repeat (3) tick();
    @(negedge clk);
    chk("t2_wr_ptr", wr_ptr, 1);

    // 3: one buffered write vs. continuous reads: forced on 16th contended cycle
    tick();
    cfg_ctrl = 8'h01;
    first_we = -1;
    for (int i = 0; i < 17; i++) begin
      rd_req = 1'b1; rd_addr = AW'(5 + i % 3);
      rq.push_back(tbl[i % 3]);
      if (i == 0) begin
        cfg_idx = 10; idx_load_stb = 1'b1; cfg_data = 8'h5A; cfg_wr_stb = 1'b1;
        wq.push_back({5'd10, 8'h5A});
      end else begin
        idx_load_stb = 1'b0; cfg_wr_stb = 1'b0;
      end
      @(negedge clk);
      if (mem_we && first_we < 0) first_we = i;
      tick();
    end
    rd_req = 1'b0;
    @(negedge clk);
    chk("t3_force_cycle", first_we, 16);
    chk("t3_late_read", {rd_valid, mem_en, mem_we}, 3'b010);
    repeat (3) tick();
    @(negedge clk);
    chk("t3_wr_ptr", wr_ptr, 10);

    // 4: reads hold the port; 5th host write overflows
    tick();
    cfg_ctrl = 8'h03;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr = 7;
      rq.push_back(8'hA3);
      if (i < 5) begin
        cfg_data = DW'(8'hC0 + i); cfg_wr_stb = 1'b1;
        if (i < 4) wq.push_back({AW'(10 + i), DW'(8'hC0 + i)});
      end else begin
        cfg_wr_stb = 1'b0;
      end
      if (i == 5) begin
        @(negedge clk);
        chk("t4_overflow", overflow, 1);
        chk("t4_wr_ptr", wr_ptr, 14);
        chk("t4_busy", busy, 1);
      end
      tick();
    end
    rd_req = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("t4_overflow_sticky", overflow, 1);
    tick();
    cfg_ctrl = 8'h00;
    tick();
    @(negedge clk);
    chk("t4_overflow_clr", overflow, 0);
    chk("t4_wr_ptr_hold", wr_ptr, 14);

    // 5: clear all 32 words, host write mid-clear lands afterwards
    tick();
    cfg_ctrl = 8'h05;
    for (int a = 0; a < 32; a++) wq.push_back({AW'(a), 8'h00});
    tick(); tick();
    for (int j = 0; j < 32; j++) begin
      if (j == 8) begin
        cfg_idx = 3; idx_load_stb = 1'b1; cfg_data = 8'h77; cfg_wr_stb = 1'b1;
        wq.push_back({5'd3, 8'h77});
      end else begin
        idx_load_stb = 1'b0; cfg_wr_stb = 1'b0;
      end
      @(negedge clk);
      chk("t5_busy_during_clear", busy, 1);
      tick();
    end
    for (int k = 0; k < 10 && busy; k++) tick();
    @(negedge clk);
    chk("t5_busy_done", busy, 0);
    chk("t5_writes_done", wq.size(), 0);

    // 6: reset mid-clear
    tick();
    cfg_ctrl = 8'h01;
    tick();
    cfg_ctrl = 8'h05;
    for (int a = 0; a < 6; a++) wq.push_back({AW'(a), 8'h00});
    tick();
    hostwr(1'b1, 9, 8'h99);
    repeat (6) tick();
    rst_n = 1'b0;
    cfg_ctrl = 8'h01;
    @(negedge clk);
    chk("t6_rst_mem_en", mem_en, 0);
    chk("t6_rst_status", {busy, overflow, wr_ptr}, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_quiet_mem_en", mem_en, 0);
      tick();
    end
    wq.push_back({5'd20, 8'hE4}); hostwr(1'b1, 20, 8'hE4);
    tick(); tick();
    rd_req = 1'b1; rd_addr = 20;
    rq.push_back(8'hE4);
    @(negedge clk);
    chk("t6_rd_grant", {mem_en, mem_we, mem_addr}, {2'b10, 5'd20});
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("t6_rd_latency", {rd_valid, rd_data}, {1'b1, 8'hE4});
    repeat (3) tick();

    chk("end_wq_empty", wq.size(), 0);
    chk("end_rq_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
